// File: rtl/flash_link_pkg.sv
// Shared definitions for the MCU link framing path: FSM encoding, status codes,
// default header bytes and the gap-counter width helper.
package flash_link_pkg;

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CSUM = 2'd3;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_CSUM    = 2'd1;
  localparam logic [1:0] STATUS_BUSY    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_HDR0 = 8'hEB;
  localparam logic [7:0] DEF_HDR1 = 8'h90;

  localparam int unsigned DEF_TIMEOUT_CYC = 24000;

  function automatic int gap_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between link bytes; expire is combinational, one cycle wide,
// and is suppressed whenever reload is asserted in the same cycle.
module byte_gap_timer
  import flash_link_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic reload_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = gap_cnt_width(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i && !reload_i && (cnt_q == W'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (reload_i || !enable_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flash_cmd_assembler.sv
// Frames the MCU byte stream (HDR0 HDR1 C3..C0 CS) into a 32-bit flash command.
// Outputs register one cycle after the CS byte; no back-pressure on rx_valid.
module flash_cmd_assembler
  import flash_link_pkg::*;
#(
  parameter logic [7:0]  HDR0        = DEF_HDR0,
  parameter logic [7:0]  HDR1        = DEF_HDR1,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        flash_busy,
  output logic [31:0] cmd,
  output logic        start_trs,
  output logic        status_valid,
  output logic [1:0]  status_code,
  output logic [7:0]  frame_err_cnt
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] cmd_q, cmd_d;
  logic        start_q, start_d;
  logic        svld_q, svld_d;
  logic [1:0]  scode_q, scode_d;
  logic [7:0]  err_q, err_d;
  logic        gap_expire;

  byte_gap_timer #(
    .CYCLES (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .reload_i (rx_valid),
    .enable_i (state_q != ST_HUNT),
    .expire_o (gap_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cmd_d    = cmd_q;
    start_d  = 1'b0;
    svld_d   = 1'b0;
    scode_d  = scode_q;
    err_d    = err_q;

    if (rx_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (rx_data == HDR0) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (rx_data == HDR1) begin
            state_d  = ST_DATA;
            idx_d    = 2'd0;
            shadow_d = '0;
            sum_d    = '0;
          end else if (rx_data != HDR0) begin
            state_d = ST_HUNT;
          end
        end
        ST_DATA: begin
          shadow_d = {shadow_q[23:0], rx_data};
          sum_d    = sum_q + rx_data;
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_CSUM;
        end
        default: begin
          state_d = ST_HUNT;
          svld_d  = 1'b1;
          if (rx_data != sum_q) begin
            scode_d = STATUS_CSUM;
          end else if (flash_busy) begin
            scode_d = STATUS_BUSY;
          end else begin
            scode_d = STATUS_OK;
            cmd_d   = shadow_q;
            start_d = 1'b1;
          end
        end
      endcase
    end else if (gap_expire) begin
      state_d = ST_HUNT;
      svld_d  = 1'b1;
      scode_d = STATUS_TIMEOUT;
    end

    if (svld_d && (scode_d != STATUS_OK) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cmd_q    <= '0;
      start_q  <= 1'b0;
      svld_q   <= 1'b0;
      scode_q  <= STATUS_OK;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cmd_q    <= cmd_d;
      start_q  <= start_d;
      svld_q   <= svld_d;
      scode_q  <= scode_d;
      err_q    <= err_d;
    end
  end

  assign cmd           = cmd_q;
  assign start_trs     = start_q;
  assign status_valid  = svld_q;
  assign status_code   = scode_q;
  assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_flash_cmd_assembler.sv
// Directed bench for flash_cmd_assembler with a queue-based frame model checked every cycle.
module tb_flash_cmd_assembler;

  localparam int unsigned T = 24000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        flash_busy;
  logic [31:0] cmd;
  logic        start_trs;
  logic        status_valid;
  logic [1:0]  status_code;
  logic [7:0]  frame_err_cnt;

  int checks;
  int failures;

  flash_cmd_assembler dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .flash_busy    (flash_busy),
    .cmd           (cmd),
    .start_trs     (start_trs),
    .status_valid  (status_valid),
    .status_code   (status_code),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: the bytes collected so far for the frame in progress.
  logic [7:0]  frm[$];
  logic [31:0] e_cmd;
  logic        e_start;
  logic        e_svld;
  logic [1:0]  e_code;
  logic [7:0]  e_err;
  logic        m_ready;
  longint      cyc;
  longint      m_last;

  task automatic report(input logic [1:0] code);
    e_svld = 1'b1;
    e_code = code;
    if (code != 2'd0 && e_err < 8'd255) e_err = e_err + 8'd1;
  endtask

  initial begin
    logic       r, v, b;
    logic [7:0] d, s;
    frm.delete();
    e_cmd = 0; e_start = 0; e_svld = 0; e_code = 0; e_err = 0;
    m_ready = 0; cyc = 0; m_last = 0;
    forever begin
      @(posedge clk);
      r = rst; v = rx_valid; d = rx_data; b = flash_busy;
      e_start = 1'b0;
      e_svld  = 1'b0;
      if (r) begin
        frm.delete();
        e_cmd = 0; e_code = 0; e_err = 0;
        m_ready = 1'b1;
      end else if (v) begin
        m_last = cyc;
        if (frm.size() == 0) begin
          if (d == 8'hEB) frm.push_back(d);
        end else if (frm.size() == 1) begin
          if (d == 8'h90) frm.push_back(d);
          else if (d != 8'hEB) frm.delete();
        end else begin
          frm.push_back(d);
          if (frm.size() == 7) begin
            s = frm[2] + frm[3] + frm[4] + frm[5];
            if (frm[6] != s) report(2'd1);
            else if (b) report(2'd2);
            else begin
              e_cmd   = {frm[2], frm[3], frm[4], frm[5]};
              e_start = 1'b1;
              report(2'd0);
            end
            frm.delete();
          end
        end
      end else if (frm.size() > 0 && (cyc - m_last) == longint'(T)) begin
        frm.delete();
        report(2'd3);
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        chk("cmd", cmd, e_cmd);
        chk("start_trs", {31'd0, start_trs}, {31'd0, e_start});
        chk("status_valid", {31'd0, status_valid}, {31'd0, e_svld});
        chk("status_code", {30'd0, status_code}, {30'd0, e_code});
        chk("frame_err_cnt", {24'd0, frame_err_cnt}, {24'd0, e_err});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c3, c2, c1, c0, cs);
    send_byte(8'hEB);
    send_byte(8'h90);
    send_byte(c3);
    send_byte(c2);
    send_byte(c1);
    send_byte(c0);
    send_byte(cs);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; flash_busy = 1'b0;
    checks = 0; failures = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", cmd, 32'h0);
    chk("rst_start", {31'd0, start_trs}, 32'd0);
    chk("rst_svld", {31'd0, status_valid}, 32'd0);
    chk("rst_code", {30'd0, status_code}, 32'd0);
    chk("rst_err", {24'd0, frame_err_cnt}, 32'd0);
    rst = 1'b0;

    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h14);
    chk("ok_start", {31'd0, start_trs}, 32'd1);
    chk("ok_cmd", cmd, 32'h12345678);
    chk("ok_model_cmd", e_cmd, 32'h12345678);
    chk("ok_code", {30'd0, status_code}, 32'd0);
    chk("ok_err", {24'd0, frame_err_cnt}, 32'd0);

    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h15);
    chk("cs_start", {31'd0, start_trs}, 32'd0);
    chk("cs_svld", {31'd0, status_valid}, 32'd1);
    chk("cs_code", {30'd0, status_code}, 32'd1);
    chk("cs_cmd", cmd, 32'h12345678);
    chk("cs_err", {24'd0, frame_err_cnt}, 32'd1);

    send_byte(8'hEB); send_byte(8'h90);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    flash_busy = 1'b1;
    send_byte(8'h0A);
    flash_busy = 1'b0;
    chk("busy_code", {30'd0, status_code}, 32'd2);
    chk("busy_start", {31'd0, start_trs}, 32'd0);
    chk("busy_cmd", cmd, 32'h12345678);

    send_byte(8'hEB);
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E);
    chk("resync_start", {31'd0, start_trs}, 32'd1);
    chk("resync_cmd", cmd, 32'hAABBCCDD);

    // Stall after C3: the report lands on the edge T cycles after that byte.
    send_byte(8'hEB); send_byte(8'h90); send_byte(8'h12);
    repeat (T - 1) @(posedge clk);
    #1;
    chk("to_early", {31'd0, status_valid}, 32'd0);
    @(posedge clk); #1;
    chk("to_svld", {31'd0, status_valid}, 32'd1);
    chk("to_code", {30'd0, status_code}, 32'd3);
    chk("to_err", {24'd0, frame_err_cnt}, 32'd3);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    chk("after_to_cmd", cmd, 32'h01020304);
    chk("after_to_start", {31'd0, start_trs}, 32'd1);

    send_byte(8'hEB); send_byte(8'h90); send_byte(8'h12);
    repeat (T - 2) @(posedge clk);
    send_byte(8'h34);
    chk("edge_no_to", {31'd0, status_valid}, 32'd0);
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h14);
    chk("edge_cmd", cmd, 32'h12345678);
    chk("edge_code", {30'd0, status_code}, 32'd0);

    send_byte(8'hEB); send_byte(8'h90); send_byte(8'h11); send_byte(8'h22);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("mid_rst_cmd", cmd, 32'h0);
    chk("mid_rst_svld", {31'd0, status_valid}, 32'd0);
    chk("mid_rst_err", {24'd0, frame_err_cnt}, 32'd0);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h77);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_tail_cmd", cmd, 32'h0);

    for (int i = 0; i < 300; i++) begin
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    end
    chk("soak_err", {24'd0, frame_err_cnt}, 32'd255);
    chk("soak_code", {30'd0, status_code}, 32'd1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
